// File: rtl/config_pkg.sv
// Core configuration shared by the front-end predictors.
// Only the fields the return-address stack needs are modelled here.
package config_pkg;

    typedef struct packed {
        int unsigned RASDepth;
        int unsigned VLEN;
    } cva6_cfg_t;

    localparam cva6_cfg_t cva6_cfg_empty = '{RASDepth: 32'd2, VLEN: 32'd32};

endpackage

// File: rtl/ras_ckpt.sv
// Return-address stack with pointer/count checkpointing for branch recovery.
// Define RAS_CKPT_RESTORE_EN to enable snapshots; otherwise restore_i behaves as a flush.
module ras_ckpt #(
    parameter config_pkg::cva6_cfg_t CVA6Cfg = config_pkg::cva6_cfg_empty,
    parameter int unsigned           DEPTH   = CVA6Cfg.RASDepth
) (
    input  logic                           clk_i,
    input  logic                           rst_ni,
    input  logic                           flush_i,
    input  logic                           push_i,
    input  logic                           pop_i,
    input  logic [CVA6Cfg.VLEN-1:0]        data_i,
    input  logic                           ckpt_i,
    input  logic                           restore_i,
    output logic [CVA6Cfg.VLEN-1:0]        data_o,
    output logic                           valid_o,
    output logic [$clog2(DEPTH+1)-1:0]     count_o
);

    localparam int VLEN = CVA6Cfg.VLEN;
    localparam int CW   = $clog2(DEPTH + 1);
    localparam int TPW  = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [VLEN-1:0] entries [DEPTH];
    logic [TPW-1:0]  tp_q, tp_d, tp_inc, tp_dec, wr_idx;
    logic [CW-1:0]   count_q, count_d;
    logic            wr_en;
    logic            restore_hit;

`ifdef RAS_CKPT_RESTORE_EN
    logic [TPW-1:0]  ckpt_tp_q, ckpt_tp_d;
    logic [CW-1:0]   ckpt_count_q, ckpt_count_d;
    logic            ckpt_valid_q, ckpt_valid_d;

    assign restore_hit = restore_i && ckpt_valid_q;
`else
    logic unused_ckpt;

    assign unused_ckpt = ckpt_i;
    assign restore_hit = restore_i;
`endif

    assign tp_inc = (tp_q == TPW'(DEPTH - 1)) ? '0 : tp_q + 1'b1;
    assign tp_dec = (tp_q == '0) ? TPW'(DEPTH - 1) : tp_q - 1'b1;

    assign data_o  = entries[tp_q];
    assign valid_o = (count_q != '0);
    assign count_o = count_q;

    // A restore (or flush) discards any same-cycle push/pop entirely.
    always_comb begin
        tp_d    = tp_q;
        count_d = count_q;
        wr_en   = 1'b0;
        wr_idx  = tp_q;
        if (flush_i) begin
            tp_d    = '0;
            count_d = '0;
        end else if (restore_hit) begin
`ifdef RAS_CKPT_RESTORE_EN
            tp_d    = ckpt_tp_q;
            count_d = ckpt_count_q;
`else
            tp_d    = '0;
            count_d = '0;
`endif
        end else if (push_i && pop_i) begin
            wr_en = 1'b1;
            if (count_q == '0) begin
                count_d = CW'(1);
            end
        end else if (push_i) begin
            tp_d   = tp_inc;
            wr_idx = tp_inc;
            wr_en  = 1'b1;
            if (count_q != CW'(DEPTH)) begin
                count_d = count_q + 1'b1;
            end
        end else if (pop_i && (count_q != '0)) begin
            tp_d    = tp_dec;
            count_d = count_q - 1'b1;
        end
    end

`ifdef RAS_CKPT_RESTORE_EN
    // Snapshot holds pre-update values; on restore it already equals the restored state.
    always_comb begin
        ckpt_tp_d    = ckpt_tp_q;
        ckpt_count_d = ckpt_count_q;
        ckpt_valid_d = ckpt_valid_q;
        if (flush_i) begin
            ckpt_valid_d = 1'b0;
        end else if (ckpt_i && !restore_hit) begin
            ckpt_tp_d    = tp_q;
            ckpt_count_d = count_q;
            ckpt_valid_d = 1'b1;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            ckpt_tp_q    <= '0;
            ckpt_count_q <= '0;
            ckpt_valid_q <= 1'b0;
        end else begin
            ckpt_tp_q    <= ckpt_tp_d;
            ckpt_count_q <= ckpt_count_d;
            ckpt_valid_q <= ckpt_valid_d;
        end
    end
`endif

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            tp_q    <= '0;
            count_q <= '0;
        end else begin
            tp_q    <= tp_d;
            count_q <= count_d;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            for (int i = 0; i < int'(DEPTH); i++) begin
                entries[i] <= '0;
            end
        end else if (wr_en) begin
            entries[wr_idx] <= data_i;
        end
    end

endmodule

// File: tb/tb_ras_ckpt.sv
// Scoreboard bench for ras_ckpt (DEPTH=2, VLEN=32): directed scenarios then random traffic.
module tb_ras_ckpt;

    localparam int D = 2;

    logic        clk;
    logic        rst_n;
    logic        flush, push, pop, ckpt, restore;
    logic [31:0] din;
    logic [31:0] dout;
    logic        vout;
    logic [1:0]  cout;

    ras_ckpt dut (
        .clk_i     (clk),
        .rst_ni    (rst_n),
        .flush_i   (flush),
        .push_i    (push),
        .pop_i     (pop),
        .data_i    (din),
        .ckpt_i    (ckpt),
        .restore_i (restore),
        .data_o    (dout),
        .valid_o   (vout),
        .count_o   (cout)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] data;
        logic        valid;
        int          cnt;
    } exp_t;

    exp_t exp_q[$];
    exp_t mon_e;
    int   n_checks = 0;
    int   n_fail   = 0;

    // Reference model: a modular stack array plus an optional snapshot.
    logic [31:0] m_mem [D];
    int          m_tp, m_cnt;
    bit          s_valid;
    int          s_tp, s_cnt;

    task automatic model_reset();
        for (int i = 0; i < D; i++) m_mem[i] = '0;
        m_tp = 0; m_cnt = 0; s_valid = 0; s_tp = 0; s_cnt = 0;
        exp_q.delete();
    endtask

    task automatic model_step(input bit p, input bit o, input bit c, input bit r,
                              input bit f, input logic [31:0] d);
        int pre_tp, pre_cnt;
        bit do_restore;
        pre_tp = m_tp; pre_cnt = m_cnt;
`ifdef RAS_CKPT_RESTORE_EN
        do_restore = r && s_valid;
`else
        do_restore = r;
`endif
        if (f) begin
            m_tp = 0; m_cnt = 0; s_valid = 0;
        end else if (do_restore) begin
`ifdef RAS_CKPT_RESTORE_EN
            m_tp = s_tp; m_cnt = s_cnt;
`else
            m_tp = 0; m_cnt = 0;
`endif
        end else begin
            if (p && o) begin
                m_mem[m_tp] = d;
                if (m_cnt == 0) m_cnt = 1;
            end else if (p) begin
                m_tp = (m_tp + 1) % D;
                m_mem[m_tp] = d;
                m_cnt = (m_cnt + 1 > D) ? D : m_cnt + 1;
            end else if (o && m_cnt > 0) begin
                m_tp = (m_tp + D - 1) % D;
                m_cnt = m_cnt - 1;
            end
`ifdef RAS_CKPT_RESTORE_EN
            if (c) begin
                s_tp = pre_tp; s_cnt = pre_cnt; s_valid = 1;
            end
`endif
        end
    endtask

    task automatic applyStimulus(input bit p, input bit o, input bit c, input bit r,
                                 input bit f, input logic [31:0] d);
        exp_t e;
        @(negedge clk);
        push = p; pop = o; ckpt = c; restore = r; flush = f; din = d;
        @(posedge clk);
        model_step(p, o, c, r, f, d);
        e.data = m_mem[m_tp]; e.valid = (m_cnt != 0); e.cnt = m_cnt;
        exp_q.push_back(e);
    endtask

    task automatic checkOutput(input string name, input logic [31:0] ed, input bit chk_d,
                               input logic ev, input int ec);
        n_checks++;
        if ((chk_d && dout !== ed) || vout !== ev || int'(cout) != ec) begin
            n_fail++;
            $display("[TB] FAIL %s: got data=%h valid=%b count=%0d, expected data=%h valid=%b count=%0d",
                     name, dout, vout, cout, ed, ev, ec);
        end
    endtask

    always @(negedge clk) begin
        while (exp_q.size() > 0) begin
            mon_e = exp_q.pop_front();
            n_checks++;
            if (dout !== mon_e.data || vout !== mon_e.valid || int'(cout) != mon_e.cnt) begin
                n_fail++;
                $display("[TB] FAIL scoreboard @%0t: got data=%h valid=%b count=%0d, expected data=%h valid=%b count=%0d",
                         $time, dout, vout, cout, mon_e.data, mon_e.valid, mon_e.cnt);
            end
        end
    end

    initial begin
        int budget;
        rst_n = 1'b0; flush = 0; push = 0; pop = 0; ckpt = 0; restore = 0; din = '0;
        model_reset();
        #2 checkOutput("reset_state", 32'h0, 1, 1'b0, 0);
        @(negedge clk); rst_n = 1'b1;

        // Push/pop basics
        applyStimulus(1, 0, 0, 0, 0, 32'h100);
        applyStimulus(1, 0, 0, 0, 0, 32'h200);
        #1 checkOutput("push2", 32'h200, 1, 1'b1, 2);
        applyStimulus(0, 1, 0, 0, 0, 32'h0);
        #1 checkOutput("pop1", 32'h100, 1, 1'b1, 1);
        applyStimulus(0, 0, 0, 0, 1, 32'h0);
        #1 checkOutput("flush", 32'h0, 0, 1'b0, 0);

        // Overflow then drain past empty
        applyStimulus(1, 0, 0, 0, 0, 32'h100);
        applyStimulus(1, 0, 0, 0, 0, 32'h200);
        applyStimulus(1, 0, 0, 0, 0, 32'h300);
        #1 checkOutput("overflow", 32'h300, 1, 1'b1, 2);
        applyStimulus(0, 1, 0, 0, 0, 32'h0);
        #1 checkOutput("ovf_pop1", 32'h200, 1, 1'b1, 1);
        applyStimulus(0, 1, 0, 0, 0, 32'h0);
        #1 checkOutput("ovf_pop2", 32'h0, 0, 1'b0, 0);
        applyStimulus(0, 1, 0, 0, 0, 32'h0);
        #1 checkOutput("pop_empty", 32'h300, 1, 1'b0, 0);

        // Simultaneous push+pop
        applyStimulus(1, 1, 0, 0, 0, 32'h40);
        #1 checkOutput("pushpop_empty", 32'h40, 1, 1'b1, 1);
        applyStimulus(1, 1, 0, 0, 0, 32'h80);
        #1 checkOutput("pushpop_nonempty", 32'h80, 1, 1'b1, 1);
        applyStimulus(0, 0, 0, 0, 1, 32'h0);

`ifdef RAS_CKPT_RESTORE_EN
        applyStimulus(1, 0, 0, 0, 0, 32'h100);
        applyStimulus(0, 0, 1, 0, 0, 32'h0);
        applyStimulus(1, 0, 0, 0, 0, 32'h200);
        applyStimulus(0, 0, 0, 1, 0, 32'h0);
        #1 checkOutput("restore", 32'h100, 1, 1'b1, 1);
        applyStimulus(1, 0, 0, 1, 0, 32'h500);
        #1 checkOutput("restore_push", 32'h100, 1, 1'b1, 1);
        applyStimulus(0, 0, 0, 1, 1, 32'h0);
        #1 checkOutput("flush_restore", 32'h0, 0, 1'b0, 0);
        applyStimulus(0, 0, 0, 1, 0, 32'h0);
        #1 checkOutput("restore_invalid", 32'h0, 0, 1'b0, 0);
`else
        applyStimulus(1, 0, 0, 0, 0, 32'h100);
        applyStimulus(1, 0, 0, 0, 0, 32'h200);
        applyStimulus(0, 0, 0, 1, 0, 32'h0);
        #1 checkOutput("restore_as_flush", 32'h0, 0, 1'b0, 0);
`endif

        // Asynchronous reset between edges with a full stack and a pending push
        applyStimulus(0, 0, 0, 0, 1, 32'h0);
        applyStimulus(1, 0, 0, 0, 0, 32'hA0);
        applyStimulus(1, 0, 0, 0, 0, 32'hB0);
        @(negedge clk);
        push = 1; din = 32'hC0;
        #1 rst_n = 1'b0;
        #1 checkOutput("async_reset", 32'h0, 1, 1'b0, 0);
        model_reset();
        @(negedge clk);
        push = 0; rst_n = 1'b1;
        applyStimulus(0, 1, 0, 0, 0, 32'h0);
        #1 checkOutput("after_reset_pop", 32'h0, 1, 1'b0, 0);

        // Random traffic
        for (int i = 0; i < 400; i++) begin
            applyStimulus($urandom_range(0, 1), $urandom_range(0, 1),
                          ($urandom_range(0, 7) == 0), ($urandom_range(0, 9) == 0),
                          ($urandom_range(0, 29) == 0), $urandom);
        end
        applyStimulus(0, 0, 0, 0, 0, 32'h0);

        budget = 10;
        while (exp_q.size() > 0 && budget > 0) begin
            @(posedge clk);
            budget--;
        end
        if (exp_q.size() > 0) begin
            n_checks++;
            n_fail++;
            $display("[TB] FAIL drain: got %0d pending, expected 0", exp_q.size());
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/ras_ckpt.md
RAS_CKPT -- requirements
Module: ras_ckpt

Interface
REQ-001 SHALL have parameter CVA6Cfg, default config_pkg::cva6_cfg_empty, meaning the core configuration; the block uses its RASDepth and VLEN fields.
REQ-002 SHALL have parameter DEPTH, default CVA6Cfg.RASDepth, meaning the number of stack entries (legal range >= 1).
REQ-003 SHALL have port clk_i, input, 1 bit, the single clock; all state updates on its rising edge.
REQ-004 SHALL have port rst_ni, input, 1 bit, asynchronous active-low reset.
REQ-005 SHALL have port flush_i, input, 1 bit, clears the stack.
REQ-006 SHALL have port push_i, input, 1 bit, call detected; pushes data_i.
REQ-007 SHALL have port pop_i, input, 1 bit, return detected; pops the top entry.
REQ-008 SHALL have port data_i, input, VLEN bits, return address to push.
REQ-009 SHALL have port ckpt_i, input, 1 bit, snapshots the stack pointer and count (speculative branch).
REQ-010 SHALL have port restore_i, input, 1 bit, restores the snapshot (mispredict).
REQ-011 SHALL have port data_o, output, VLEN bits, top entry (predicted return address).
REQ-012 SHALL have port valid_o, output, 1 bit, stack non-empty.
REQ-013 SHALL have port count_o, output, $clog2(DEPTH+1) bits, current occupancy.

Function
REQ-014 SHALL store entries in a circular buffer indexed by a top pointer tp, modulo DEPTH.
REQ-015 SHALL drive data_o = entry[tp] and valid_o = (count != 0) combinationally from registers, with zero input-to-output latency.
REQ-016 SHALL on push only: set tp <= (tp+1) mod DEPTH, write data_i into the new tp, and set count <= min(count+1, DEPTH); when full, the oldest entry SHALL be silently overwritten.
REQ-017 SHALL on pop only with count > 0: set tp <= (tp-1) mod DEPTH and count <= count-1; a pop when empty SHALL be ignored.
REQ-018 SHALL on push and pop in the same cycle: overwrite entry[tp] with data_i with tp unchanged; count stays unchanged if > 0, and becomes 1 if it was 0.
REQ-019 SHALL give the update priority flush_i > restore_i > push_i/pop_i.
REQ-020 SHALL on flush_i: set tp <= 0 and count <= 0; entry contents are not cleared; any snapshot is invalidated.
REQ-021 SHALL on ckpt_i: capture the pre-update tp and count of the same cycle, even when push or pop is also asserted.
REQ-022 SHALL on restore_i with a valid snapshot: set tp and count to the snapshot values and discard any same-cycle push or pop; restore without a valid snapshot SHALL be ignored.
REQ-023 SHALL on ckpt_i together with restore_i: perform the restore and then re-capture the restored values as the new snapshot.
REQ-024 SHALL not repair entries overwritten after a checkpoint (pointer-only recovery).

Reset
REQ-025 SHALL on rst_ni low, asynchronously and regardless of clk_i: set tp=0, count=0, all entries=0, snapshot invalid; hence data_o=0, valid_o=0 and count_o=0.
REQ-026 SHALL, if reset is asserted mid-operation, abandon any pending push, pop or restore; the first clock edge after release behaves as from an empty stack.

Configuration
REQ-027 SHALL gate the snapshot feature with the macro RAS_CKPT_RESTORE_EN: when defined, REQ-021 to REQ-023 apply.
REQ-028 SHALL, when RAS_CKPT_RESTORE_EN is undefined: omit the snapshot registers, ignore ckpt_i, and treat restore_i as flush_i (tp=0, count=0).

Verification (DEPTH=2, VLEN=32)
REQ-029 SHALL cover: push 0x100 then push 0x200 -> data_o=0x200, count_o=2; pop -> data_o=0x100, count_o=1.
REQ-030 SHALL cover: push 0x100, 0x200, 0x300 (overflow) -> count_o=2, data_o=0x300; pop -> data_o=0x200; pop -> valid_o=0; a further pop -> no change.
REQ-031 SHALL cover: on an empty stack, push 0x40 and pop in the same cycle -> count_o=1, data_o=0x40; then push 0x80 and pop together -> count_o=1, data_o=0x80.
REQ-032 SHALL cover: push 0x100, ckpt_i, push 0x200, restore_i -> count_o=1, data_o=0x100; restore_i with push_i in the same cycle -> push discarded.
REQ-033 SHALL cover: flush_i and restore_i asserted together with a valid snapshot -> count_o=0; a later restore_i -> ignored, count_o=0.
REQ-034 SHALL cover: rst_ni dropped between clock edges with count_o=2 -> valid_o=0 and data_o=0 immediately; build with RAS_CKPT_RESTORE_EN undefined -> restore_i empties the stack.
